// File: rtl/ifu_swc.sv
// ifu_swc: single-issue fetch unit with execute window; IFU_SWC_RETIRE_CNT_EN enables the retire counter
module ifu_swc #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [3:0]  CYC_LAST = 4'd4
) (
  input  logic        hclk,
  input  logic        hrst,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  input  logic        hready,
  input  logic [31:0] hrdata,
  input  logic        hresp,
  input  logic        redirect_vld,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ifu_inst,
  output logic        ifu_dec_stall,
  output logic [3:0]  cycle_cnt,
  output logic [31:0] ifu_pc,
  output logic        ifu_fault,
  output logic [31:0] ifu_retire_cnt
);
  typedef enum logic [1:0] {FETCH_A, FETCH_D, EXEC, FAULT} state_t;
  state_t      state;
  logic [31:0] pc;
  logic [31:0] rd_pc;
  logic        rd_vld;
  logic        retire;
  logic        redir;
  logic [31:0] nxt_pc;
  // next fetch address: a same-cycle strobe beats the latched target, which beats sequential pc+4
  always_comb begin
    retire = state == EXEC && cycle_cnt == CYC_LAST;
    redir  = redirect_vld | rd_vld;
    nxt_pc = redirect_vld ? redirect_pc : rd_vld ? rd_pc : ifu_pc + 32'd4;
  end
  assign haddr         = hrst ? RESET_PC : pc;
  assign htrans        = state == FETCH_A && !hrst ? 2'b10 : 2'b00;
  assign ifu_dec_stall = state != EXEC;
  assign ifu_fault     = state == FAULT;
  // fetch / execute sequencer; FAULT is left only through reset
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state     <= FETCH_A;
      pc        <= RESET_PC;
      ifu_inst  <= 32'h0000_0013;
      ifu_pc    <= RESET_PC;
      cycle_cnt <= 4'd0;
      rd_vld    <= 1'b0;
      rd_pc     <= 32'd0;
    end else begin
      case (state)
        FETCH_A: if (hready) state <= FETCH_D;
        FETCH_D: if (hready) begin
          if (hresp) state <= FAULT;
          else begin
            ifu_inst <= hrdata;
            ifu_pc   <= pc;
            state    <= EXEC;
          end
        end
        EXEC: begin
          if (redirect_vld) begin
            rd_vld <= 1'b1;
            rd_pc  <= redirect_pc;
          end
          cycle_cnt <= cycle_cnt + 4'd1;
          if (retire) begin
            cycle_cnt <= 4'd0;
            rd_vld    <= 1'b0;
            pc        <= nxt_pc;
            state     <= redir && |nxt_pc[1:0] ? FAULT : FETCH_A;
          end
        end
        default: ;
      endcase
    end
  end
`ifdef IFU_SWC_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
  // count every retire, including the one that precedes a misaligned-redirect fault
  always_ff @(posedge hclk) begin
    if (hrst) retire_cnt <= 32'd0;
    else if (retire) retire_cnt <= retire_cnt + 32'd1;
  end
  assign ifu_retire_cnt = retire_cnt;
`else
  assign ifu_retire_cnt = 32'd0;
`endif
endmodule

// File: tb/tb_ifu_swc.sv
// tb_ifu_swc: directed self-checking bench for ifu_swc
module tb_ifu_swc;
  logic        hclk = 1'b0;
  logic        hrst = 1'b1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready = 1'b1;
  logic [31:0] hrdata;
  logic        hresp = 1'b0;
  logic        redirect_vld = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic [31:0] ifu_inst;
  logic        ifu_dec_stall;
  logic [3:0]  cycle_cnt;
  logic [31:0] ifu_pc;
  logic        ifu_fault;
  logic [31:0] ifu_retire_cnt;
  logic [31:0] daddr = 32'd0;
  int checks = 0;
  int errors = 0;
`ifdef IFU_SWC_RETIRE_CNT_EN
  localparam int RC_EN = 1;
`else
  localparam int RC_EN = 0;
`endif

  ifu_swc dut (
    .hclk(hclk), .hrst(hrst), .haddr(haddr), .htrans(htrans), .hready(hready),
    .hrdata(hrdata), .hresp(hresp), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .ifu_inst(ifu_inst), .ifu_dec_stall(ifu_dec_stall), .cycle_cnt(cycle_cnt),
    .ifu_pc(ifu_pc), .ifu_fault(ifu_fault), .ifu_retire_cnt(ifu_retire_cnt)
  );

  always #5 hclk = ~hclk;

  always @(posedge hclk) if (htrans == 2'b10 && hready) daddr <= haddr;
  always_comb hrdata = daddr == 32'd0 ? 32'h0000_0093 : daddr ^ 32'h1300_0000;

  task tick;
    @(posedge hclk);
    #1;
  endtask

  task do_reset;
    hrst = 1'b1;
    hready = 1'b1;
    hresp = 1'b0;
    redirect_vld = 1'b0;
    tick;
    tick;
    hrst = 1'b0;
    #1;
  endtask

  task run_insn(input logic r, input logic [31:0] t);
    tick;
    tick;
    repeat (4) tick;
    redirect_vld = r;
    redirect_pc = t;
    tick;
    redirect_vld = 1'b0;
  endtask

  task test_reset;
    hrst = 1'b1;
    tick;
    tick;
    checks++; if (htrans !== 2'b00) begin errors++; $display("FAIL rst_htrans got %h exp 0", htrans); end
    checks++; if (haddr !== 32'd0) begin errors++; $display("FAIL rst_haddr got %h exp 0", haddr); end
    checks++; if (ifu_inst !== 32'h13) begin errors++; $display("FAIL rst_inst got %h exp 13", ifu_inst); end
    checks++; if ({ifu_dec_stall, cycle_cnt, ifu_fault} !== 6'b1_0000_0) begin errors++; $display("FAIL rst_ctl got %b exp 100000", {ifu_dec_stall, cycle_cnt, ifu_fault}); end
    checks++; if (ifu_pc !== 32'd0 || ifu_retire_cnt !== 32'd0) begin errors++; $display("FAIL rst_pc_cnt got %h/%h exp 0/0", ifu_pc, ifu_retire_cnt); end
  endtask

  task test_basic;
    hrst = 1'b0;
    #1;
    checks++; if (htrans !== 2'b10 || haddr !== 32'd0) begin errors++; $display("FAIL first_fetch got %h@%h exp 2@0", htrans, haddr); end
    tick;
    checks++; if (htrans !== 2'b00 || ifu_dec_stall !== 1'b1) begin errors++; $display("FAIL data_phase got %h/%b exp 0/1", htrans, ifu_dec_stall); end
    tick;
    checks++; if (ifu_inst !== 32'h93 || ifu_dec_stall !== 1'b0) begin errors++; $display("FAIL first_inst got %h/%b exp 93/0", ifu_inst, ifu_dec_stall); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (cycle_cnt !== 4'(i)) begin errors++; $display("FAIL cyc_cnt got %0d exp %0d", cycle_cnt, i); end
      tick;
    end
    checks++; if (htrans !== 2'b10 || haddr !== 32'd4 || ifu_dec_stall !== 1'b1 || cycle_cnt !== 4'd0) begin errors++; $display("FAIL next_fetch got %h@%h exp 2@4", htrans, haddr); end
  endtask

  task test_wait_states;
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++; if (haddr !== 32'd4 || htrans !== 2'b10 || ifu_dec_stall !== 1'b1) begin errors++; $display("FAIL wait_a got %h@%h exp 2@4", htrans, haddr); end
    end
    hready = 1'b1;
    tick;
    hready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick;
      checks++; if (ifu_dec_stall !== 1'b1 || ifu_inst !== 32'h93 || haddr !== 32'd4) begin errors++; $display("FAIL wait_d got %b/%h exp 1/93", ifu_dec_stall, ifu_inst); end
    end
    hready = 1'b1;
    tick;
    checks++; if (ifu_inst !== 32'h1300_0004 || ifu_pc !== 32'd4 || ifu_dec_stall !== 1'b0) begin errors++; $display("FAIL wait_cap got %h/%h exp 13000004/4", ifu_inst, ifu_pc); end
  endtask

  task test_redirect;
    tick;
    tick;
    checks++; if (cycle_cnt !== 4'd2) begin errors++; $display("FAIL redir_cnt got %0d exp 2", cycle_cnt); end
    redirect_vld = 1'b1;
    redirect_pc = 32'h100;
    tick;
    redirect_vld = 1'b0;
    tick;
    redirect_vld = 1'b1;
    redirect_pc = 32'h200;
    tick;
    redirect_vld = 1'b0;
    checks++; if (haddr !== 32'h200 || htrans !== 2'b10) begin errors++; $display("FAIL redir_last got %h exp 200", haddr); end
    redirect_vld = 1'b1;
    redirect_pc = 32'h300;
    tick;
    tick;
    redirect_vld = 1'b0;
    checks++; if (ifu_inst !== 32'h1300_0200 || ifu_pc !== 32'h200) begin errors++; $display("FAIL redir_inst got %h/%h exp 13000200/200", ifu_inst, ifu_pc); end
    repeat (5) tick;
    checks++; if (haddr !== 32'h204) begin errors++; $display("FAIL redir_ignored got %h exp 204", haddr); end
  endtask

  task test_wrap;
    run_insn(1'b1, 32'hFFFF_FFFC);
    checks++; if (haddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_tgt got %h exp fffffffc", haddr); end
    run_insn(1'b0, 32'd0);
    checks++; if (ifu_pc !== 32'hFFFF_FFFC || ifu_inst !== 32'hECFF_FFFC) begin errors++; $display("FAIL wrap_pc got %h/%h exp fffffffc/ecfffffc", ifu_pc, ifu_inst); end
    checks++; if (haddr !== 32'd0 || htrans !== 2'b10) begin errors++; $display("FAIL wrap_next got %h exp 0", haddr); end
  endtask

  task test_retire_cnt;
    do_reset;
    repeat (5) run_insn(1'b0, 32'd0);
    checks++; if (ifu_retire_cnt !== 32'(5 * RC_EN)) begin errors++; $display("FAIL retire_cnt got %0d exp %0d", ifu_retire_cnt, 5 * RC_EN); end
    checks++; if (haddr !== 32'd20) begin errors++; $display("FAIL retire_haddr got %h exp 14", haddr); end
  endtask

  task test_misalign;
    run_insn(1'b1, 32'h102);
    checks++; if (ifu_fault !== 1'b1 || htrans !== 2'b00 || ifu_dec_stall !== 1'b1 || cycle_cnt !== 4'd0) begin errors++; $display("FAIL mis_fault got %b/%h exp 1/0", ifu_fault, htrans); end
    checks++; if (ifu_retire_cnt !== 32'(6 * RC_EN)) begin errors++; $display("FAIL mis_retire got %0d exp %0d", ifu_retire_cnt, 6 * RC_EN); end
    redirect_vld = 1'b1;
    redirect_pc = 32'h40;
    repeat (8) tick;
    redirect_vld = 1'b0;
    checks++; if (ifu_fault !== 1'b1 || htrans !== 2'b00 || ifu_dec_stall !== 1'b1) begin errors++; $display("FAIL mis_sticky got %b/%h exp 1/0", ifu_fault, htrans); end
    do_reset;
    checks++; if (ifu_fault !== 1'b0 || htrans !== 2'b10 || haddr !== 32'd0) begin errors++; $display("FAIL mis_clear got %b/%h@%h exp 0/2@0", ifu_fault, htrans, haddr); end
  endtask

  task test_hresp;
    tick;
    hresp = 1'b1;
    tick;
    hresp = 1'b0;
    checks++; if (ifu_fault !== 1'b1 || htrans !== 2'b00 || ifu_inst !== 32'h13) begin errors++; $display("FAIL hresp_fault got %b/%h/%h exp 1/0/13", ifu_fault, htrans, ifu_inst); end
    repeat (3) tick;
    checks++; if (ifu_fault !== 1'b1 || htrans !== 2'b00) begin errors++; $display("FAIL hresp_sticky got %b/%h exp 1/0", ifu_fault, htrans); end
  endtask

  task test_reset_mid_exec;
    do_reset;
    run_insn(1'b1, 32'h80);
    tick;
    tick;
    tick;
    checks++; if (ifu_dec_stall !== 1'b0 || cycle_cnt !== 4'd1 || ifu_pc !== 32'h80) begin errors++; $display("FAIL mid_exec got %b/%0d/%h exp 0/1/80", ifu_dec_stall, cycle_cnt, ifu_pc); end
    hrst = 1'b1;
    tick;
    checks++; if (ifu_dec_stall !== 1'b1 || cycle_cnt !== 4'd0 || ifu_pc !== 32'd0 || ifu_inst !== 32'h13 || htrans !== 2'b00) begin errors++; $display("FAIL mid_rst got %b/%0d/%h/%h exp 1/0/0/13", ifu_dec_stall, cycle_cnt, ifu_pc, ifu_inst); end
    hrst = 1'b0;
    #1;
    checks++; if (htrans !== 2'b10 || haddr !== 32'd0) begin errors++; $display("FAIL mid_refetch got %h@%h exp 2@0", htrans, haddr); end
    run_insn(1'b0, 32'd0);
    checks++; if (haddr !== 32'd4) begin errors++; $display("FAIL mid_latch got %h exp 4", haddr); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wait_states;
    test_redirect;
    test_wrap;
    test_retire_cnt;
    test_misalign;
    test_hresp;
    test_reset_mid_exec;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ifu_swc.md
IFU_SWC -- requirements
Module: ifu_swc

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, fetch address used after reset.
REQ-002 Parameter CYC_LAST, default 4'd4, final cycle_cnt value of each instruction's execute window (legal range 1..15).
REQ-003 hclk  in  1  single clock; all state updates on rising edge.
REQ-004 hrst  in  1  reset, synchronous, active-high.
REQ-005 haddr  out  32  instruction-bus address.
REQ-006 htrans  out  2  bus transfer type: 2'b00 IDLE, 2'b10 NONSEQ only.
REQ-007 hready  in  1  bus ready (address accept / data valid).
REQ-008 hrdata  in  32  instruction-bus read data.
REQ-009 hresp  in  1  bus error, sampled in data phase with hready.
REQ-010 redirect_vld  in  1  jump/branch-taken strobe from execute.
REQ-011 redirect_pc  in  32  redirect target.
REQ-012 ifu_inst  out  32  instruction to decoder inst_in.
REQ-013 ifu_dec_stall  out  1  decoder stall; 1 = ifu_inst not valid.
REQ-014 cycle_cnt  out  4  execute-window cycle index to decoder.
REQ-015 ifu_pc  out  32  PC of ifu_inst.
REQ-016 ifu_fault  out  1  sticky fetch fault.
REQ-017 ifu_retire_cnt  out  32  retired-instruction count (see Configuration).

Function
REQ-018 State machine SHALL have states FETCH_A, FETCH_D, EXEC, FAULT.
REQ-019 FETCH_A: htrans=NONSEQ, haddr=pc; on hready=1 go FETCH_D, else hold with address stable.
REQ-020 FETCH_D: htrans=IDLE; on hready=1 and hresp=0 capture hrdata into ifu_inst, pc into ifu_pc, go EXEC; on hready=1 and hresp=1 go FAULT; hready=0 holds.
REQ-021 EXEC: ifu_dec_stall=0; cycle_cnt increments by 1 per cycle from 0; at cycle_cnt==CYC_LAST, cycle_cnt wraps to 0, instruction retires, state goes FETCH_A.
REQ-022 ifu_dec_stall SHALL be 1 and cycle_cnt 0 in every state other than EXEC.
REQ-023 Minimum instruction period with zero-wait bus SHALL be 2 + (CYC_LAST+1) cycles.
REQ-024 redirect_vld SHALL be sampled only in EXEC; latched target replaces pc+4 as next pc; last strobe in the window wins; strobes outside EXEC ignored.
REQ-025 Redirect on the CYC_LAST cycle SHALL take effect for the immediately following fetch.
REQ-026 Without redirect, next pc = ifu_pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-027 Latched redirect_pc with bits [1:0] != 0 SHALL, at retire, enter FAULT instead of FETCH_A.
REQ-028 FAULT: ifu_fault=1, htrans=IDLE, ifu_dec_stall=1, cycle_cnt=0; exit only by reset.
REQ-029 ifu_inst and ifu_pc SHALL hold their value outside FETCH_D capture.

Reset
REQ-030 hrst=1 SHALL force next-state FETCH_A, pc=RESET_PC, haddr=RESET_PC, htrans=IDLE while hrst=1, ifu_inst=32'h0000_0013, ifu_pc=RESET_PC, ifu_dec_stall=1, cycle_cnt=0, ifu_fault=0, ifu_retire_cnt=0, redirect latch cleared.
REQ-031 Reset asserted mid-transfer or mid-EXEC SHALL abandon the operation; first NONSEQ at RESET_PC appears the cycle after hrst deasserts.

Configuration
REQ-032 Macro IFU_SWC_RETIRE_CNT_EN defined: ifu_retire_cnt increments by 1 (wrapping at 2^32) on each retire of REQ-021, including the retire that precedes entering FAULT.
REQ-033 Macro undefined: ifu_retire_cnt port present, tied to 0, no counter register.

Verification
REQ-034 Reset, zero-wait bus returning 32'h0000_0093 at 0 -> NONSEQ at 0 on the first cycle after reset, ifu_inst=32'h0000_0093 with stall=0 three cycles after reset, cycle_cnt 0..4, next haddr=4.
REQ-035 hready low 3 cycles in FETCH_A and 2 in FETCH_D -> haddr stable, stall=1 throughout, instruction captured only on the hready-high cycle.
REQ-036 redirect_vld at cycle_cnt=2 with 32'h0000_0100, then at 4 with 32'h0000_0200 -> next haddr=32'h0000_0200.
REQ-037 redirect_pc=32'h0000_0102 -> ifu_fault=1 after retire, htrans IDLE until hrst; hresp=1 in data phase -> same FAULT response.
REQ-038 ifu_pc=32'hFFFF_FFFC, no redirect -> next haddr=0; with IFU_SWC_RETIRE_CNT_EN, 5 retires -> ifu_retire_cnt=5, without it -> 0.
